// File: rtl/sto_stack.sv
// sto_stack: parametrised LIFO of DEPTH signed WIDTH-bit words with a registered
// read port. Words pushed in the forward pass come back in reverse order for BPTT.
// Optional feature: define STO_STACK_ERR_EN to build the sticky misuse flag on
// err. Without it, err is tied low.
module sto_stack #(
  parameter  int WIDTH = 32,
  parameter  int DEPTH = 8,
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    clr,
  input  logic                    push,
  input  logic                    pop,
  input  logic signed [WIDTH-1:0] i,
  output logic signed [WIDTH-1:0] o,
  output logic [CW-1:0]           count,
  output logic                    empty,
  output logic                    full,
  output logic                    err
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  // The storage array is deliberately not reset; nothing reads it while count is 0.
  logic signed [WIDTH-1:0] mem_q [DEPTH];
  logic signed [WIDTH-1:0] o_q, o_d;
  logic [CW-1:0]           count_q, count_d;
  logic [AW-1:0]           top_idx, wr_idx, mem_wa;
  logic                    mem_we;
  logic                    empty_w, full_w;

  assign empty_w = (count_q == '0);
  assign full_w  = (count_q == CW'(DEPTH));
  // top_idx wraps when the stack is empty, but it is only used when count > 0.
  assign top_idx = AW'(count_q - CW'(1));
  // wr_idx is only used for a push when not full, so count fits in AW bits.
  assign wr_idx  = AW'(count_q);

  // Next-state decode: clr wins, then push&pop swap/bypass, then single ops.
  always_comb begin
    count_d = count_q;
    o_d     = o_q;
    mem_we  = 1'b0;
    mem_wa  = wr_idx;
    if (clr) begin
      count_d = '0;
    end else if (push && pop) begin
      if (empty_w) begin
        o_d = i;
      end else begin
        o_d    = mem_q[top_idx];
        mem_we = 1'b1;
        mem_wa = top_idx;
      end
    end else if (push) begin
      if (!full_w) begin
        mem_we  = 1'b1;
        mem_wa  = wr_idx;
        count_d = count_q + CW'(1);
      end
    end else if (pop) begin
      if (!empty_w) begin
        o_d     = mem_q[top_idx];
        count_d = count_q - CW'(1);
      end
    end
  end

  // Control state: output word and occupancy count.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      o_q     <= '0;
      count_q <= '0;
    end else begin
      o_q     <= o_d;
      count_q <= count_d;
    end
  end

  // Storage array write port; push data always comes straight from i.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem_q[mem_wa] <= i;
    end
  end

`ifdef STO_STACK_ERR_EN
  logic err_q, err_d, ignored;

  assign ignored = (push && !pop && full_w) || (pop && !push && empty_w);

  // Sticky misuse flag: set by any ignored op, cleared only by clr or reset.
  always_comb begin
    err_d = err_q;
    if (clr) begin
      err_d = 1'b0;
    end else if (ignored) begin
      err_d = 1'b1;
    end
  end

  // Misuse flag register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

  assign o     = o_q;
  assign count = count_q;
  assign empty = empty_w;
  assign full  = full_w;

endmodule

// File: tb/tb_sto_stack.sv
// tb_sto_stack: table-driven vectors, hand-written reset sequences and a
// randomized run against a queue-based LIFO reference model for sto_stack
// (WIDTH=32, DEPTH=4). Follows STO_STACK_ERR_EN when checking err.
module tb_sto_stack;

  localparam int WIDTH = 32;
  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH + 1);
`ifdef STO_STACK_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic                    clk = 1'b0;
  logic                    rst;
  logic                    clr;
  logic                    push;
  logic                    pop;
  logic signed [WIDTH-1:0] i;
  logic signed [WIDTH-1:0] o;
  logic [CW-1:0]           count;
  logic                    empty;
  logic                    full;
  logic                    err;

  int checks   = 0;
  int failures = 0;
  int txn      = 0;

  sto_stack #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk   (clk),
    .rst   (rst),
    .clr   (clr),
    .push  (push),
    .pop   (pop),
    .i     (i),
    .o     (o),
    .count (count),
    .empty (empty),
    .full  (full),
    .err   (err)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit                      c;
    bit                      pu;
    bit                      po;
    logic signed [WIDTH-1:0] d;
    logic signed [WIDTH-1:0] eo;
    int                      ec;
    bit                      eerr;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t v(bit c, bit pu, bit po, int d, int eo, int ec, bit eerr);
    vec_t r;
    r.c = c; r.pu = pu; r.po = po; r.d = d; r.eo = eo; r.ec = ec; r.eerr = eerr;
    return r;
  endfunction

  // Behavioural reference: a queue whose back is the top of the stack.
  logic signed [WIDTH-1:0] m_stack[$];
  logic signed [WIDTH-1:0] m_o;
  bit                      m_err;

  task automatic model_reset();
    m_stack.delete();
    m_o   = '0;
    m_err = 1'b0;
  endtask

  task automatic model_step(bit c, bit pu, bit po, logic signed [WIDTH-1:0] d);
    if (c) begin
      m_stack.delete();
      m_err = 1'b0;
    end else if (pu && po) begin
      if (m_stack.size() == 0) m_o = d;
      else begin
        m_o = m_stack[$];
        m_stack[m_stack.size()-1] = d;
      end
    end else if (pu) begin
      if (m_stack.size() < DEPTH) m_stack.push_back(d);
      else if (ERR_EN) m_err = 1'b1;
    end else if (po) begin
      if (m_stack.size() > 0) m_o = m_stack.pop_back();
      else if (ERR_EN) m_err = 1'b1;
    end
  endtask

  task automatic chk(string name, logic [WIDTH-1:0] act, logic [WIDTH-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL txn=%0d %s actual=%0h required=%0h", txn, name, act, exp);
    end
  endtask

  task automatic check_all(string tag, logic signed [WIDTH-1:0] eo, int ec, bit eerr);
    $display("txn %0d %s: clr=%0b push=%0b pop=%0b i=%0d -> o=%0d count=%0d empty=%0b full=%0b err=%0b",
             txn, tag, clr, push, pop, i, o, count, empty, full, err);
    chk({tag, ".o"},     o, eo);
    chk({tag, ".count"}, WIDTH'(count), WIDTH'(ec));
    chk({tag, ".empty"}, WIDTH'(empty), WIDTH'(ec == 0));
    chk({tag, ".full"},  WIDTH'(full),  WIDTH'(ec == DEPTH));
    chk({tag, ".err"},   WIDTH'(err),   WIDTH'(ERR_EN & eerr));
    txn++;
  endtask

  // Drive one cycle of inputs, clock it, sample 1 time unit after the edge.
  task automatic do_op(bit c, bit pu, bit po, logic signed [WIDTH-1:0] d);
    clr = c; push = pu; pop = po; i = d;
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst = 1'b0; clr = 1'b0; push = 1'b0; pop = 1'b0; i = '0;
    #1;
    check_all("reset", 0, 0, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    model_reset();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b0; clr = 1'b0; push = 1'b0; pop = 1'b0; i = '0;

    // Test 1: push 10,20,30 then pop x3.
    vecs.push_back(v(0,1,0, 10,  0, 1, 0));
    vecs.push_back(v(0,1,0, 20,  0, 2, 0));
    vecs.push_back(v(0,1,0, 30,  0, 3, 0));
    vecs.push_back(v(0,0,1,  0, 30, 2, 0));
    vecs.push_back(v(0,0,1,  0, 20, 1, 0));
    vecs.push_back(v(0,0,1,  0, 10, 0, 0));
    // Test 2: fill, overflow push ignored, drain, clr.
    vecs.push_back(v(0,1,0,  1, 10, 1, 0));
    vecs.push_back(v(0,1,0,  2, 10, 2, 0));
    vecs.push_back(v(0,1,0,  3, 10, 3, 0));
    vecs.push_back(v(0,1,0,  4, 10, 4, 0));
    vecs.push_back(v(0,1,0,  5, 10, 4, 1));
    vecs.push_back(v(0,0,1,  0,  4, 3, 1));
    vecs.push_back(v(0,0,1,  0,  3, 2, 1));
    vecs.push_back(v(0,0,1,  0,  2, 1, 1));
    vecs.push_back(v(0,0,1,  0,  1, 0, 1));
    vecs.push_back(v(1,0,0,  0,  1, 0, 0));
    // Test 3 (mid-run): pop on empty, o holds; clr clears err.
    vecs.push_back(v(0,0,1,  0,  1, 0, 1));
    vecs.push_back(v(1,0,0,  0,  1, 0, 0));
    // Test 4: push 7, push 9 & pop, pop.
    vecs.push_back(v(0,1,0,  7,  1, 1, 0));
    vecs.push_back(v(0,1,1,  9,  7, 1, 0));
    vecs.push_back(v(0,0,1,  0,  9, 0, 0));
    // Test 5: bypass on empty.
    vecs.push_back(v(0,1,1, -5, -5, 0, 0));
    // clr has priority over push and pop; o holds across clr.
    vecs.push_back(v(0,1,0,  3, -5, 1, 0));
    vecs.push_back(v(0,1,0,  8, -5, 2, 0));
    vecs.push_back(v(1,1,0, 99, -5, 0, 0));
    vecs.push_back(v(0,1,0, 11, -5, 1, 0));
    vecs.push_back(v(0,0,1,  0, 11, 0, 0));
    vecs.push_back(v(0,1,0, 12, 11, 1, 0));
    vecs.push_back(v(1,0,1,  0, 11, 0, 0));
    // push & pop when full: swap top, count stays DEPTH.
    vecs.push_back(v(0,1,0,  1, 11, 1, 0));
    vecs.push_back(v(0,1,0,  2, 11, 2, 0));
    vecs.push_back(v(0,1,0,  3, 11, 3, 0));
    vecs.push_back(v(0,1,0,  4, 11, 4, 0));
    vecs.push_back(v(0,1,1, 50,  4, 4, 0));
    vecs.push_back(v(0,0,1,  0, 50, 3, 0));
    vecs.push_back(v(0,0,1,  0,  3, 2, 0));
    vecs.push_back(v(1,0,0,  0,  3, 0, 0));

    apply_reset();
    foreach (vecs[k]) begin
      do_op(vecs[k].c, vecs[k].pu, vecs[k].po, vecs[k].d);
      check_all("vec", vecs[k].eo, vecs[k].ec, vecs[k].eerr);
    end

    // Test 3: pop on empty straight after reset keeps o at 0.
    apply_reset();
    do_op(0, 0, 1, 32'sd77);
    check_all("pop_empty", 0, 0, 1'b1);
    do_op(1, 0, 0, 0);
    check_all("clr_err", 0, 0, 1'b0);

    // Test 6: asynchronous reset in the middle of a cycle.
    do_op(0, 1, 0, 1);
    do_op(0, 1, 0, 2);
    do_op(0, 0, 1, 0);
    check_all("pre_rst", 2, 1, 1'b0);
    clr = 1'b0; push = 1'b0; pop = 1'b0;
    #2;
    rst = 1'b0;
    #1;
    check_all("async_rst", 0, 0, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    do_op(0, 1, 0, 6);
    check_all("post_rst_push", 0, 1, 1'b0);
    do_op(0, 0, 1, 0);
    check_all("post_rst_pop", 6, 0, 1'b0);

    // Randomized run against the reference model.
    apply_reset();
    for (int n = 0; n < 400; n++) begin
      bit c, pu, po;
      logic signed [WIDTH-1:0] d;
      c  = ($urandom_range(0, 39) == 0);
      pu = $urandom_range(0, 1);
      po = $urandom_range(0, 2) == 0 ? 1'b1 : ($urandom_range(0, 1) == 1);
      d  = $urandom;
      do_op(c, pu, po, d);
      model_step(c, pu, po, d);
      check_all("rand", m_o, m_stack.size(), m_err);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
